// File: rtl/dl_entry_if.sv
// rtl/dl_entry_if.sv - button/code handshake bundle between the entry sequencer and its neighbours
interface dl_entry_if #(
    parameter int DIGITS = 3
);
    logic [3:0]                     digit;
    logic                           confirm_getter;
    logic                           confirm_fsm;
    logic                           backspace;
    logic                           ack;
    logic [4*DIGITS-1:0]            code;
    logic [$clog2(DIGITS+1)-1:0]    count;
    logic [3:0]                     last_digit;
    logic                           req;
    logic                           error;
    logic                           timeout;
    logic [1:0]                     state;

    modport master (
        output digit, confirm_getter, confirm_fsm, backspace, ack,
        input  code, count, last_digit, req, error, timeout, state
    );

    modport slave (
        input  digit, confirm_getter, confirm_fsm, backspace, ack,
        output code, count, last_digit, req, error, timeout, state
    );
endinterface

// File: rtl/dl_entry_sequencer.sv
// rtl/dl_entry_sequencer.sv - digit entry, idle timeout and req/ack hand-off for the lock FSM
// Optional backspace button enabled by defining DL_ENTRY_BACKSPACE_EN.
module dl_entry_sequencer #(
    parameter int DIGITS  = 3,
    parameter int TIMEOUT = 500
) (
    input  logic        clk,
    input  logic        rst,
    dl_entry_if.slave   bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int KW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        REQ   = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  code, code_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic [3:0]     last_digit, last_nxt;
    logic           error, error_nxt;
    logic           timeout, timeout_nxt;
    logic [TW-1:0]  idle_cnt, idle_nxt;

    logic getter_prev, submit_prev;
    logic getter_edge, submit_edge, back_edge;
    logic sub_ev, bk_ev, gt_ev;
    logic do_append, do_remove, do_tick, do_clear;

    // Previous-value registers reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            getter_prev <= 1'b1;
            submit_prev <= 1'b1;
        end else begin
            getter_prev <= bus.confirm_getter;
            submit_prev <= bus.confirm_fsm;
        end
    end

    assign getter_edge = bus.confirm_getter & ~getter_prev;
    assign submit_edge = bus.confirm_fsm & ~submit_prev;

`ifdef DL_ENTRY_BACKSPACE_EN
    logic back_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_prev <= 1'b1;
        end else begin
            back_prev <= bus.backspace;
        end
    end

    assign back_edge = bus.backspace & ~back_prev;
`else
    logic unused_backspace;

    assign unused_backspace = bus.backspace;
    assign back_edge        = 1'b0;
`endif

    // One event per cycle: submit beats backspace beats getter; losers vanish silently.
    assign sub_ev = submit_edge;
    assign bk_ev  = back_edge & ~submit_edge;
    assign gt_ev  = getter_edge & ~submit_edge & ~back_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            code       <= '0;
            count      <= '0;
            last_digit <= 4'd0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            code       <= code_nxt;
            count      <= count_nxt;
            last_digit <= last_nxt;
            error      <= error_nxt;
            timeout    <= timeout_nxt;
            idle_cnt   <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        code_nxt    = code;
        count_nxt   = count;
        last_nxt    = last_digit;
        error_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        idle_nxt    = '0;
        do_append   = 1'b0;
        do_remove   = 1'b0;
        do_tick     = 1'b0;
        do_clear    = 1'b0;

        unique case (state)
            IDLE: begin
                if (sub_ev) begin
                    error_nxt = 1'b1;
                end else if (gt_ev) begin
                    do_append = 1'b1;
                end
            end
            ENTRY: begin
                if (sub_ev) begin
                    error_nxt = 1'b1;
                end else if (bk_ev) begin
                    do_remove = 1'b1;
                end else if (gt_ev) begin
                    do_append = 1'b1;
                end else begin
                    do_tick = 1'b1;
                end
            end
            FULL: begin
                if (sub_ev) begin
                    state_nxt = REQ;
                end else if (bk_ev) begin
                    do_remove = 1'b1;
                end else if (gt_ev) begin
                    error_nxt = 1'b1;
                end else begin
                    do_tick = 1'b1;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    do_clear = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_append) begin
            code_nxt  = {code[KW-5:0], bus.digit};
            count_nxt = count + 1'b1;
            last_nxt  = bus.digit;
            state_nxt = (count == CW'(DIGITS - 1)) ? FULL : ENTRY;
        end

        if (do_remove) begin
            code_nxt  = code >> 4;
            count_nxt = count - 1'b1;
            last_nxt  = (count == CW'(1)) ? 4'd0 : code[7:4];
            state_nxt = (count == CW'(1)) ? IDLE : ENTRY;
        end

        // Quiet cycles in ENTRY/FULL count up; the terminal count discards the entry.
        if (do_tick) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
                do_clear    = 1'b1;
                timeout_nxt = 1'b1;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end

        if (do_clear) begin
            code_nxt  = '0;
            count_nxt = '0;
            last_nxt  = 4'd0;
            state_nxt = IDLE;
        end
    end

    assign bus.code       = code;
    assign bus.count      = count;
    assign bus.last_digit = last_digit;
    assign bus.req        = (state == REQ);
    assign bus.error      = error;
    assign bus.timeout    = timeout;
    assign bus.state      = state;
endmodule

// File: tb/tb_dl_entry_sequencer.sv
// tb/tb_dl_entry_sequencer.sv - self-checking bench for dl_entry_sequencer
module tb_dl_entry_sequencer;
    localparam int DIGITS  = 3;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dl_entry_if #(.DIGITS(DIGITS)) bus ();

    dl_entry_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the entry is a queue of digits, the state follows from its length.
    int mq[$];
    bit m_req, m_err, m_to;
    int m_last, m_quiet;
    bit pg, ps, pb;

    task automatic model_reset();
        mq.delete();
        m_req = 0; m_err = 0; m_to = 0;
        m_last = 0; m_quiet = 0;
        pg = 1; ps = 1; pb = 1;
    endtask

    task automatic model_step();
        bit ge, se, be;
        ge = bus.confirm_getter && !pg;
        se = bus.confirm_fsm && !ps;
`ifdef DL_ENTRY_BACKSPACE_EN
        be = bus.backspace && !pb;
`else
        be = 0;
`endif
        m_err = 0;
        m_to  = 0;
        if (m_req) begin
            if (bus.ack) begin
                m_req = 0; mq.delete(); m_last = 0; m_quiet = 0;
            end
        end else if (se) begin
            m_quiet = 0;
            if (mq.size() == DIGITS) m_req = 1;
            else m_err = 1;
        end else if (be) begin
            m_quiet = 0;
            if (mq.size() > 0) begin
                void'(mq.pop_back());
                m_last = (mq.size() > 0) ? mq[mq.size()-1] : 0;
            end
        end else if (ge) begin
            m_quiet = 0;
            if (mq.size() < DIGITS) begin
                mq.push_back(int'(bus.digit));
                m_last = int'(bus.digit);
            end else begin
                m_err = 1;
            end
        end else if (mq.size() > 0) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                mq.delete(); m_last = 0; m_to = 1; m_quiet = 0;
            end
        end
        pg = bus.confirm_getter;
        ps = bus.confirm_fsm;
        pb = bus.backspace;
    endtask

    function automatic logic [31:0] model_code();
        logic [31:0] c = 0;
        foreach (mq[i]) c = (c << 4) | 32'(mq[i]);
        return c;
    endfunction

    function automatic logic [31:0] model_state();
        if (m_req) return 3;
        if (mq.size() == 0) return 0;
        if (mq.size() == DIGITS) return 2;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("code",    32'(bus.code),       model_code());
        chk("count",   32'(bus.count),      32'(mq.size()));
        chk("last",    32'(bus.last_digit), 32'(m_last));
        chk("req",     32'(bus.req),        32'(m_req));
        chk("error",   32'(bus.error),      32'(m_err));
        chk("timeout", 32'(bus.timeout),    32'(m_to));
        chk("state",   32'(bus.state),      model_state());
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic apply(input logic g, input logic s, input logic b, input logic a, input logic [3:0] d);
        bus.confirm_getter = g;
        bus.confirm_fsm    = s;
        bus.backspace      = b;
        bus.ack            = a;
        bus.digit          = d;
        cyc();
    endtask

    typedef struct {
        logic        g, s, a;
        logic [3:0]  d;
        logic [11:0] code;
        logic [1:0]  cnt;
        logic [3:0]  last;
        logic        req, err;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic g, logic s, logic a, logic [3:0] d, logic [11:0] code,
                                logic [1:0] cnt, logic [3:0] last, logic req, logic err, logic [1:0] st);
        vec_t v;
        v.g = g; v.s = s; v.a = a; v.d = d; v.code = code; v.cnt = cnt;
        v.last = last; v.req = req; v.err = err; v.st = st;
        return v;
    endfunction

    initial begin
        //              g  s  a  d      code     cnt last  req err st
        tbl.push_back(mk(0, 0, 0, 4'hB, 12'h000, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'hB, 12'h00B, 1, 4'hB, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'hA, 12'h00B, 1, 4'hB, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 4'hA, 12'h0BA, 2, 4'hA, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'hA, 12'h0BA, 2, 4'hA, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'hA, 12'h0BA, 2, 4'hA, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 4'hD, 12'h0BA, 2, 4'hA, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 4'hD, 12'hBAD, 3, 4'hD, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'hF, 12'hBAD, 3, 4'hD, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 4'hF, 12'hBAD, 3, 4'hD, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 4'hF, 12'hBAD, 3, 4'hD, 0, 0, 2));
        tbl.push_back(mk(1, 1, 0, 4'hF, 12'hBAD, 3, 4'hD, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'hF, 12'hBAD, 3, 4'hD, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 4'hF, 12'hBAD, 3, 4'hD, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 4'hF, 12'h000, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4'hF, 12'h000, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 12'h000, 0, 4'h0, 0, 0, 0));

        // Reset with every button held high.
        bus.confirm_getter = 1; bus.confirm_fsm = 1; bus.backspace = 1;
        bus.ack = 0; bus.digit = 4'h7;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code",  32'(bus.code), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_last",  32'(bus.last_digit), 0);
        chk("rst_req",   32'(bus.req), 0);
        chk("rst_err",   32'(bus.error), 0);
        chk("rst_to",    32'(bus.timeout), 0);
        chk("rst_state", 32'(bus.state), 0);
        @(negedge clk);
        rst = 0;
        cyc();
        cyc();
        chk("held_no_event", 32'(bus.count), 0);

        foreach (tbl[i]) begin
            apply(tbl[i].g, tbl[i].s, 1'b0, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_code", i),  32'(bus.code),       32'(tbl[i].code));
            chk($sformatf("tbl%0d_count", i), 32'(bus.count),      32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_last", i),  32'(bus.last_digit), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_req", i),   32'(bus.req),        32'(tbl[i].req));
            chk($sformatf("tbl%0d_err", i),   32'(bus.error),      32'(tbl[i].err));
            chk($sformatf("tbl%0d_state", i), 32'(bus.state),      32'(tbl[i].st));
        end

        // Backspace after entering 9,1.
        apply(1, 0, 0, 0, 4'h9);
        apply(0, 0, 0, 0, 4'h9);
        apply(1, 0, 0, 0, 4'h1);
        apply(0, 0, 0, 0, 4'h1);
        chk("bs_pre_code", 32'(bus.code), 32'h091);
        apply(0, 0, 1, 0, 4'h0);
`ifdef DL_ENTRY_BACKSPACE_EN
        chk("bs1_code",  32'(bus.code), 32'h009);
        chk("bs1_count", 32'(bus.count), 1);
        chk("bs1_last",  32'(bus.last_digit), 9);
`else
        chk("bs1_code",  32'(bus.code), 32'h091);
        chk("bs1_count", 32'(bus.count), 2);
        chk("bs1_last",  32'(bus.last_digit), 1);
`endif
        apply(0, 0, 0, 0, 4'h0);
        apply(0, 0, 1, 0, 4'h0);
`ifdef DL_ENTRY_BACKSPACE_EN
        chk("bs2_state", 32'(bus.state), 0);
        chk("bs2_count", 32'(bus.count), 0);
`else
        chk("bs2_state", 32'(bus.state), 1);
        chk("bs2_count", 32'(bus.count), 2);
`endif
        bus.backspace = 0;
        repeat (25) cyc();
        chk("bs_flushed", 32'(bus.state), 0);

        // Timeout exactly TIMEOUT cycles after the last event.
        apply(1, 0, 0, 0, 4'h5);
        chk("to_entry", 32'(bus.state), 1);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            apply(0, 0, 0, 0, 4'h0);
            if (k < TIMEOUT) begin
                chk($sformatf("to_wait%0d", k), 32'(bus.timeout), 0);
            end else if (k == TIMEOUT) begin
                chk("to_pulse", 32'(bus.timeout), 1);
                chk("to_count", 32'(bus.count), 0);
                chk("to_state", 32'(bus.state), 0);
            end else begin
                chk("to_one_cycle", 32'(bus.timeout), 0);
            end
        end
        for (int k = 0; k < 30; k++) begin
            apply(0, 0, 0, 0, 4'h0);
            chk("idle_quiet", 32'(bus.timeout), 0);
        end

        // Reset while a request is pending aborts at once.
        for (int k = 0; k < DIGITS; k++) begin
            apply(1, 0, 0, 0, 4'(k + 1));
            apply(0, 0, 0, 0, 4'(k + 1));
        end
        apply(0, 1, 1, 0, 4'h0);
        chk("rq_req", 32'(bus.req), 1);
        chk("rq_code", 32'(bus.code), 32'h123);
        apply(1, 0, 0, 0, 4'h0);
        chk("rq_frozen", 32'(bus.code), 32'h123);
        #1 rst = 1;
        #1;
        chk("rq_rst_req",   32'(bus.req), 0);
        chk("rq_rst_state", 32'(bus.state), 0);
        chk("rq_rst_code",  32'(bus.code), 0);
        model_reset();
        bus.confirm_getter = 0; bus.confirm_fsm = 0; bus.backspace = 0;
        @(negedge clk);
        rst = 0;
        cyc();

        // Randomized traffic in dense and sparse bursts so timeouts also occur.
        for (int seg = 0; seg < 60; seg++) begin
            int dense = $urandom_range(0, 1);
            int len   = $urandom_range(10, 60);
            int lim   = dense ? 3 : 40;
            for (int i = 0; i < len; i++) begin
                logic g, s, b, a;
                g = ($urandom_range(0, lim - 1) == 0) ? ~bus.confirm_getter : bus.confirm_getter;
                s = ($urandom_range(0, lim + 2) == 0) ? ~bus.confirm_fsm : bus.confirm_fsm;
                b = ($urandom_range(0, lim + 1) == 0) ? ~bus.backspace : bus.backspace;
                a = ($urandom_range(0, 3) == 0);
                apply(g, s, b, a, 4'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
